// File: rtl/bram_read_arbiter_pkg.sv
// Shared constants and types for the banked BRAM read arbiter.
// Bank count, requester ID width and the pipeline tag carried alongside each read.
package bram_read_arbiter_pkg;

    localparam int SELECT      = 2;
    localparam int NUM_BANKS   = 1 << SELECT;
    localparam int REQ_ID_W    = 2;
    localparam int ARB_N       = 4;
    localparam int BANK_ADDR_W = 10;

    typedef struct packed {
        logic                vld;
        logic [REQ_ID_W-1:0] id;
        logic [SELECT-1:0]   bank;
    } pipe_tag_t;

    function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [SELECT-1:0] bank);
        return NUM_BANKS'(1) << bank;
    endfunction

endpackage

// File: rtl/bram_read_arbiter_rr_arbiter.sv
// 4-way round-robin arbiter: one-hot grant of the first request at or after the pointer.
// Latency: grant is combinational; pointer advances past the winner on accept.
// Backpressure: grant is held (not accepted) until the caller signals accept.
module rr_arbiter
    import bram_read_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [ARB_N-1:0]    req,
    input  logic                accept,
    output logic [ARB_N-1:0]    grant,
    output logic [REQ_ID_W-1:0] grant_id
);

    logic [REQ_ID_W-1:0] rr_ptr_q;
    logic [REQ_ID_W-1:0] rr_ptr_d;
    logic [REQ_ID_W-1:0] idx;
    logic                found;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = '0;
        for (int k = 0; k < ARB_N; k++) begin
            idx = rr_ptr_q + REQ_ID_W'(k);
            if (!found && req[idx]) begin
                found     = 1'b1;
                grant[idx] = 1'b1;
                grant_id  = idx;
            end
        end
        // No grant may be offered while the block is held in reset.
        if (rst) begin
            grant    = '0;
            grant_id = '0;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = grant_id + REQ_ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/bram_read_arbiter.sv
// Round-robin read scheduler for four banked BRAMs; optional response register via BRAM_ARB_RSP_REG_EN.
// Latency: accept edge to response is 2 cycles (3 with BRAM_ARB_RSP_REG_EN).
// Backpressure: requests wait for req_ready; responses are never stalled.
module bram_read_arbiter
    import bram_read_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4
)
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_BANKS-1:0]           bram_en,
    output logic [ADDR_WIDTH-SELECT-1:0]   bram_addr,
    output logic [SELECT-1:0]              sel,
    input  logic [DATA_WIDTH-1:0]          rdata_in,
    output logic                           rsp_valid,
    output logic [REQ_ID_W-1:0]            rsp_id,
    output logic [DATA_WIDTH-1:0]          rsp_data
);

    localparam int WORD_W = ADDR_WIDTH - SELECT;

    logic [NUM_REQ-1:0]    grant;
    logic [REQ_ID_W-1:0]   grant_id;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [SELECT-1:0]     win_bank;
    logic [WORD_W-1:0]     win_word;

    rr_arbiter u_rr_arbiter (
        .clk      (clk),
        .rst      (rst),
        .req      (req_valid),
        .accept   (accept),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign req_ready = grant;
    assign accept    = |(req_valid & grant);

    always_comb begin
        win_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == REQ_ID_W'(i)) begin
                win_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign win_bank = win_addr[ADDR_WIDTH-1 -: SELECT];
    assign win_word = win_addr[WORD_W-1:0];

    // Stage 1 drives the banks; stage 2 lines the mux select up with read data.
    logic [NUM_BANKS-1:0] bram_en_q;
    logic [NUM_BANKS-1:0] bram_en_d;
    logic [WORD_W-1:0]    bram_addr_q;
    logic [WORD_W-1:0]    bram_addr_d;
    pipe_tag_t            s1_q;
    pipe_tag_t            s1_d;
    pipe_tag_t            s2_q;
    pipe_tag_t            s2_d;

    always_comb begin
        bram_en_d   = '0;
        bram_addr_d = bram_addr_q;
        s1_d.vld    = accept;
        s1_d.id     = grant_id;
        s1_d.bank   = win_bank;
        if (accept) begin
            bram_en_d   = bank_onehot(win_bank);
            bram_addr_d = win_word;
        end
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bram_en_q   <= '0;
            bram_addr_q <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
        end else begin
            bram_en_q   <= bram_en_d;
            bram_addr_q <= bram_addr_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
        end
    end

    assign bram_en   = bram_en_q;
    assign bram_addr = bram_addr_q;
    assign sel       = s2_q.bank;

`ifdef BRAM_ARB_RSP_REG_EN
    logic                  rsp_vld_q;
    logic                  rsp_vld_d;
    logic [REQ_ID_W-1:0]   rsp_id_q;
    logic [REQ_ID_W-1:0]   rsp_id_d;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic [DATA_WIDTH-1:0] rsp_data_d;

    always_comb begin
        rsp_vld_d  = s2_q.vld;
        rsp_id_d   = s2_q.id;
        rsp_data_d = rdata_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_vld_q  <= 1'b0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            rsp_vld_q  <= rsp_vld_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_vld_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
`else
    assign rsp_valid = s2_q.vld;
    assign rsp_id    = s2_q.id;
    assign rsp_data  = rdata_in;
`endif

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Bench for bram_read_arbiter: grant vectors from a table, responses checked against a scoreboard.
module tb_bram_read_arbiter;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int NR = 4;
`ifdef BRAM_ARB_RSP_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR-1:0]     req_ready;
    logic [3:0]        bram_en;
    logic [9:0]        bram_addr;
    logic [1:0]        sel;
    logic [DW-1:0]     rdata_in;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [DW-1:0]     rsp_data;

    bram_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .bram_en   (bram_en),
        .bram_addr (bram_addr),
        .sel       (sel),
        .rdata_in  (rdata_in),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc_cnt = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [7:0] mem_fn(input logic [1:0] b, input logic [9:0] w);
        return 8'(int'(b) * 61 + int'(w) * 13 + 7);
    endfunction

    // Four banks with one-cycle synchronous read, muxed by sel.
    logic [7:0] bank_q [4];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (bram_en[b]) bank_q[b] <= mem_fn(2'(b), bram_addr);
        end
    end
    assign rdata_in = bank_q[sel];

    typedef struct {
        int         id;
        logic [7:0] data;
        int         bank;
        int         due;
    } exp_t;
    exp_t sb[$];

    typedef struct packed {
        logic [3:0]  rv;
        logic [47:0] addrs;
        logic [3:0]  exp_rdy;
    } vec_t;
    vec_t tbl [10];

    logic [3:0] m_en;
    logic [9:0] m_addr;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc_cnt);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 id=%0d expected no response at cycle %0d", rsp_id, cyc_cnt);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(e.id));
                check("rsp_data", 32'(rsp_data), 32'(e.data));
                check("rsp_latency", 32'(cyc_cnt), 32'(e.due));
`ifndef BRAM_ARB_RSP_REG_EN
                check("sel", 32'(sel), 32'(e.bank));
`endif
            end
        end
    end

    // One cycle: drive, check grant, record expected read, then check stage-1 outputs.
    task automatic cyc(input logic [3:0] rv, input logic [47:0] addrs, input logic [3:0] exp_rdy, input string nm);
        logic       acc;
        int         gid;
        logic [11:0] a;
        req_valid = rv;
        req_addr  = addrs;
        #1;
        check({nm, "_ready"}, 32'(req_ready), 32'(exp_rdy));
        acc = 1'b0;
        gid = 0;
        for (int i = 0; i < 4; i++) begin
            if (exp_rdy[i] && rv[i]) begin
                acc = 1'b1;
                gid = i;
            end
        end
        if (acc) begin
            a = addrs[gid*12 +: 12];
            sb.push_back('{gid, mem_fn(a[11:10], a[9:0]), int'(a[11:10]), cyc_cnt + LAT});
            m_en   = 4'(1) << a[11:10];
            m_addr = a[9:0];
        end else begin
            m_en = 4'b0000;
        end
        @(posedge clk);
        #1;
        check({nm, "_bram_en"}, 32'(bram_en), 32'(m_en));
        check({nm, "_bram_addr"}, 32'(bram_addr), 32'(m_addr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{4'b0001, {12'h000, 12'h000, 12'h000, 12'h805}, 4'b0001};
        tbl[1] = '{4'b0000, {12'h000, 12'h000, 12'h000, 12'h000}, 4'b0000};
        tbl[2] = '{4'b1111, {12'hABC, 12'h789, 12'h456, 12'h123}, 4'b0010};
        tbl[3] = '{4'b1010, {12'hABC, 12'h000, 12'h456, 12'h000}, 4'b1000};
        tbl[4] = '{4'b0010, {12'h000, 12'h000, 12'h456, 12'h000}, 4'b0010};
        tbl[5] = '{4'b0001, {12'h000, 12'h000, 12'h000, 12'hFFF}, 4'b0001};
        tbl[6] = '{4'b1100, {12'h400, 12'h3FF, 12'h000, 12'h000}, 4'b0100};
        tbl[7] = '{4'b0111, {12'h000, 12'h803, 12'h002, 12'h001}, 4'b0001};
        tbl[8] = '{4'b1001, {12'hC0F, 12'h000, 12'h000, 12'h001}, 4'b1000};
        tbl[9] = '{4'b0110, {12'h000, 12'h803, 12'h002, 12'h000}, 4'b0010};

        rst       = 1'b1;
        req_valid = 4'b1111;
        req_addr  = '0;
        m_en      = '0;
        m_addr    = '0;
        #1;
        check("ready_in_reset", 32'(req_ready), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_bram_en", 32'(bram_en), 32'h0);
        check("reset_bram_addr", 32'(bram_addr), 32'h0);
        check("reset_sel", 32'(sel), 32'h0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_rsp_id", 32'(rsp_id), 32'h0);
        rst       = 1'b0;
        req_valid = '0;

        for (int v = 0; v < 10; v++) begin
            cyc(tbl[v].rv, tbl[v].addrs, tbl[v].exp_rdy, $sformatf("vec%0d", v));
        end
        for (int i = 0; i < 4; i++) cyc(4'b0000, '0, 4'b0000, "idle_a");

        // Two reads in flight, then a one-cycle reset discards both.
        cyc(4'b0001, {36'h0, 12'h805}, 4'b0001, "flight_a");
        cyc(4'b0010, {24'h0, 12'hC07, 12'h0}, 4'b0010, "flight_b");
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_addr  = {12'hC00, 12'h800, 12'h400, 12'h000};
        #1;
        check("ready_mid_reset", 32'(req_ready), 32'h0);
        sb.delete();
        @(posedge clk);
        #1;
        m_en   = '0;
        m_addr = '0;
        check("post_reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("post_reset_bram_en", 32'(bram_en), 32'h0);
        rst = 1'b0;

        // All four requesting: rotation 0,1,2,3,0 starting from req0.
        cyc(4'b1111, {12'hC00, 12'h800, 12'h400, 12'h000}, 4'b0001, "all_g0");
        check("post_reset_rsp_valid2", 32'(rsp_valid), 32'h0);
        cyc(4'b1111, {12'hC00, 12'h800, 12'h400, 12'h000}, 4'b0010, "all_g1");
        cyc(4'b1111, {12'hC00, 12'h800, 12'h400, 12'h000}, 4'b0100, "all_g2");
        cyc(4'b1111, {12'hC00, 12'h800, 12'h400, 12'h000}, 4'b1000, "all_g3");
        cyc(4'b1111, {12'hC01, 12'h801, 12'h401, 12'h001}, 4'b0001, "all_g0b");

        // Back-to-back reads to banks 0, 1, 3 from one requester.
        cyc(4'b0100, {12'h0, 12'h000, 24'h0}, 4'b0100, "bank0");
        cyc(4'b0100, {12'h0, 12'h400, 24'h0}, 4'b0100, "bank1");
        cyc(4'b0100, {12'h0, 12'hC00, 24'h0}, 4'b0100, "bank3");

        for (int i = 0; i < 6; i++) cyc(4'b0000, '0, 4'b0000, "drain");
        check("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
